// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encoding, stage indices and helpers for the
// pipeline hazard/stall controller.
package hazard_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BR_WAIT = 2'd1,
      ST_DRAIN   = 2'd2,
      ST_TAKE    = 2'd3
   } trap_state_e;

   // Actions the trap sequencer asks of the priority logic.
   typedef struct packed {
      logic stall_id;
      logic take;
   } trap_act_t;

   localparam int IDX_IFID  = 0;
   localparam int IDX_IDEX  = 1;
   localparam int IDX_EXMEM = 2;
   localparam int IDX_MEMWB = 3;

   // Wide enough for LOAD_USE_CYCLES-1 with LOAD_USE_CYCLES up to 7.
   localparam int LU_CNT_W = 3;

   function automatic trap_act_t action_of(input trap_state_e st);
      trap_act_t a;
      a.stall_id = (st == ST_BR_WAIT) || (st == ST_DRAIN);
      a.take     = (st == ST_TAKE);
      return a;
   endfunction

endpackage

// File: rtl/hazard_trap_fsm.sv
// hazard_trap_fsm: syscall trap sequencer with drain counter and the
// deferred-interrupt latch. Exports a registered state-action vector.
//
// state      | meaning
// ST_IDLE    | no trap sequence in progress
// ST_BR_WAIT | syscall held in ID until no branch is in flight
// ST_DRAIN   | older instructions draining, drain_cnt counting down
// ST_TAKE    | trap vector loaded this cycle
module hazard_trap_fsm
   import hazard_pkg::*;
#(
   parameter int NUM_STAGES = 4
) (
   input  logic      clock,
   input  logic      reset,
   input  logic      mem_ready,
   input  logic      syscall_id,
   input  logic      branch_inflight,
   input  logic      pend_set,
   input  logic      int_take,
   input  logic      redirect,
   output logic      int_pend,
   output trap_act_t act
);

   localparam int DW = $clog2(NUM_STAGES);
   localparam logic [DW-1:0] DRAIN_INIT = DW'(NUM_STAGES - 2);

   trap_state_e   state;
   logic [DW-1:0] drain_cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         drain_cnt <= '0;
         int_pend  <= 1'b0;
         act       <= '0;
      end else if (!mem_ready) begin
         if (pend_set) int_pend <= 1'b1;
      end else if (int_take || redirect) begin
         state     <= ST_IDLE;
         act       <= action_of(ST_IDLE);
         drain_cnt <= '0;
         if (int_take) int_pend <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (syscall_id) begin
                  drain_cnt <= DRAIN_INIT;
                  if (branch_inflight) begin
                     state <= ST_BR_WAIT;
                     act   <= action_of(ST_BR_WAIT);
                  end else begin
                     state <= ST_DRAIN;
                     act   <= action_of(ST_DRAIN);
                  end
               end
            end
            ST_BR_WAIT: begin
               if (!branch_inflight) begin
                  state <= ST_DRAIN;
                  act   <= action_of(ST_DRAIN);
               end
            end
            ST_DRAIN: begin
               // Leave on the cycle the count would reach zero so DRAIN lasts NUM_STAGES-2 cycles.
               if (drain_cnt <= DW'(1)) begin
                  drain_cnt <= '0;
                  state     <= ST_TAKE;
                  act       <= action_of(ST_TAKE);
               end else begin
                  drain_cnt <= drain_cnt - DW'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
               act   <= action_of(ST_IDLE);
            end
         endcase
      end
   end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: stall/bubble/PC-write controller beside decode.
// Optional memory-stall watchdog enabled by defining HAZARD_MEM_TIMEOUT_EN.
module hazard_ctrl_unit
   import hazard_pkg::*;
#(
   parameter int NUM_STAGES      = 4,
   parameter int REG_W           = 5,
   parameter int NUM_SRC         = 3,
   parameter int LOAD_USE_CYCLES = 1,
   parameter int TIMEOUT_CYCLES  = 256
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_SRC-1:0]       src_valid,
   input  logic [NUM_SRC*REG_W-1:0] src_reg,
   input  logic [REG_W-1:0]         idex_rd,
   input  logic                     idex_memread,
   input  logic                     idex_memwrite,
   input  logic                     id_memread,
   input  logic                     mem_ready,
   input  logic                     jump_id,
   input  logic                     syscall_id,
   input  logic                     idex_branch,
   input  logic                     exmem_branch,
   input  logic                     branch_taken_mem,
   input  logic                     int_trap,
   input  logic                     flush_pipeline,
   output logic [NUM_STAGES-1:0]    bubble,
   output logic [NUM_STAGES-1:0]    write_en,
   output logic                     write_pc,
   output logic                     trap_take
`ifdef HAZARD_MEM_TIMEOUT_EN
   ,
   output logic                     mem_timeout
`endif
);

   localparam logic [LU_CNT_W-1:0] LU_INIT = LU_CNT_W'(LOAD_USE_CYCLES - 1);

   logic                int_pend;
   logic                int_req;
   logic                pend_set;
   logic                src_hit;
   logic                lu_hazard;
   logic                lu_stall;
   logic                ld_st;
   logic [LU_CNT_W-1:0] lu_cnt;
   trap_act_t           act;

   assign int_req = int_trap | int_pend;

`ifdef HAZARD_MEM_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] to_cnt;
   logic          to_hit;

   // The watchdog expiry is routed through the pending-interrupt latch to get one trap.
   assign to_hit   = !mem_ready && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
   assign pend_set = int_trap | to_hit;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         to_cnt      <= '0;
         mem_timeout <= 1'b0;
      end else if (mem_ready) begin
         to_cnt <= '0;
      end else begin
         if (to_hit) mem_timeout <= 1'b1;
         if (to_cnt != TW'(TIMEOUT_CYCLES)) to_cnt <= to_cnt + TW'(1);
      end
   end
`else
   assign pend_set = int_trap;
`endif

   hazard_trap_fsm #(
      .NUM_STAGES(NUM_STAGES)
   ) u_trap_fsm (
      .clock          (clock),
      .reset          (reset),
      .mem_ready      (mem_ready),
      .syscall_id     (syscall_id),
      .branch_inflight(idex_branch | exmem_branch),
      .pend_set       (pend_set),
      .int_take       (int_req),
      .redirect       (branch_taken_mem),
      .int_pend       (int_pend),
      .act            (act)
   );

   always_comb begin
      src_hit = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (src_valid[i] && (src_reg[i*REG_W +: REG_W] == idex_rd)) src_hit = 1'b1;
      end
   end

   assign lu_hazard = idex_memread && (idex_rd != '0) && src_hit;
   assign lu_stall  = lu_hazard || (lu_cnt != '0);
   assign ld_st     = id_memread && idex_memwrite;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lu_cnt <= '0;
      end else if (mem_ready) begin
         if (int_req || branch_taken_mem) begin
            lu_cnt <= '0;
         end else if (!act.stall_id && !act.take) begin
            if (lu_cnt != '0)   lu_cnt <= lu_cnt - LU_CNT_W'(1);
            else if (lu_hazard) lu_cnt <= LU_INIT;
         end
      end
   end

   always_comb begin
      bubble    = '0;
      write_en  = '1;
      write_pc  = 1'b1;
      trap_take = 1'b0;
      if (reset) begin
         trap_take = 1'b0;
      end else if (!mem_ready) begin
         write_en = '0;
         write_pc = 1'b0;
      end else if (int_req) begin
         bubble    = '1;
         trap_take = 1'b1;
      end else begin
         if (branch_taken_mem) begin
            bubble[IDX_IFID]  = 1'b1;
            bubble[IDX_IDEX]  = 1'b1;
            bubble[IDX_EXMEM] = 1'b1;
         end else if (act.take) begin
            bubble    = '1;
            trap_take = 1'b1;
         end else if (act.stall_id || ld_st || lu_stall) begin
            bubble[IDX_IDEX]   = 1'b1;
            write_en[IDX_IFID] = 1'b0;
            write_pc           = 1'b0;
         end else if (jump_id) begin
            bubble[IDX_IFID] = 1'b1;
         end
         if (flush_pipeline) bubble[IDX_IFID] = 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit (NUM_STAGES=4, NUM_SRC=3, LOAD_USE_CYCLES=2);
// watchdog checks run when HAZARD_MEM_TIMEOUT_EN is defined.
module tb_hazard_ctrl_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic [2:0]  src_valid;
   logic [14:0] src_reg;
   logic [4:0]  idex_rd;
   logic        idex_memread, idex_memwrite, id_memread, mem_ready;
   logic        jump_id, syscall_id, idex_branch, exmem_branch;
   logic        branch_taken_mem, int_trap, flush_pipeline;
   logic [3:0]  bubble, write_en;
   logic        write_pc, trap_take;
`ifdef HAZARD_MEM_TIMEOUT_EN
   logic        mem_timeout;
`endif
   logic [9:0]  outs;

   int n_cmp = 0;
   int n_bad = 0;

   // {bubble, write_en, write_pc, trap_take}
   localparam logic [9:0] O_DEF   = 10'b0000_1111_1_0;
   localparam logic [9:0] O_STALL = 10'b0010_1110_0_0;
   localparam logic [9:0] O_TRAP  = 10'b1111_1111_1_1;
   localparam logic [9:0] O_FRZ   = 10'b0000_0000_0_0;
   localparam logic [9:0] O_BR    = 10'b0111_1111_1_0;
   localparam logic [9:0] O_JMP   = 10'b0001_1111_1_0;
   localparam logic [9:0] O_LSJF  = 10'b0011_1110_0_0;

   hazard_ctrl_unit #(
      .NUM_STAGES(4), .REG_W(5), .NUM_SRC(3), .LOAD_USE_CYCLES(2), .TIMEOUT_CYCLES(8)
   ) dut (
      .clock(clock), .reset(reset),
      .src_valid(src_valid), .src_reg(src_reg), .idex_rd(idex_rd),
      .idex_memread(idex_memread), .idex_memwrite(idex_memwrite),
      .id_memread(id_memread), .mem_ready(mem_ready),
      .jump_id(jump_id), .syscall_id(syscall_id),
      .idex_branch(idex_branch), .exmem_branch(exmem_branch),
      .branch_taken_mem(branch_taken_mem), .int_trap(int_trap),
      .flush_pipeline(flush_pipeline),
      .bubble(bubble), .write_en(write_en), .write_pc(write_pc), .trap_take(trap_take)
`ifdef HAZARD_MEM_TIMEOUT_EN
      , .mem_timeout(mem_timeout)
`endif
   );

   always #5 clock = ~clock;
   assign outs = {bubble, write_en, write_pc, trap_take};

   task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %b expected %b", tag, got, exp);
      end
   endtask

   task automatic idle_in();
      src_valid = '0; src_reg = '0; idex_rd = '0;
      idex_memread = 0; idex_memwrite = 0; id_memread = 0; mem_ready = 1;
      jump_id = 0; syscall_id = 0; idex_branch = 0; exmem_branch = 0;
      branch_taken_mem = 0; int_trap = 0; flush_pipeline = 0;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      idle_in();
      reset = 1'b1;
      mem_ready = 0; jump_id = 1;
      #3;
      chk("reset_out", outs, O_DEF);
      tick(); tick();
      idle_in();
      reset = 1'b0;
      #1 chk("idle_default", outs, O_DEF);

      // Load-use: src2 = r7 against load into r7, two stall cycles
      tick();
      idex_memread = 1; idex_rd = 5'd7; src_valid = 3'b100;
      src_reg = {5'd7, 5'd3, 5'd1};
      #1 chk("lu_cyc0", outs, O_STALL);
      tick();
      idex_memread = 0;
      #1 chk("lu_cyc1", outs, O_STALL);
      tick();
      #1 chk("lu_done", outs, O_DEF);
      tick();
      idex_memread = 1; idex_rd = 5'd0; src_valid = 3'b001; src_reg = '0;
      #1 chk("lu_rd0", outs, O_DEF);
      tick();
      idle_in();

      // Memory stall for 5 cycles, interrupt in cycle 2, taken when ready returns
      for (int k = 0; k < 5; k++) begin
         mem_ready = 0; int_trap = (k == 1);
         flush_pipeline = (k == 3);
         #1 chk($sformatf("freeze_%0d", k), outs, O_FRZ);
         tick();
      end
      idle_in();
      #1 chk("int_deferred_take", outs, O_TRAP);
      tick();
      #1 chk("int_cleared", outs, O_DEF);
      tick();

      // Syscall with branch in MEM, then branch taken cancels it
      syscall_id = 1; exmem_branch = 1;
      #1 chk("sc_br_issue", outs, O_DEF);
      tick();
      syscall_id = 0;
      #1 chk("sc_br_wait", outs, O_STALL);
      tick();
      branch_taken_mem = 1;
      #1 chk("br_taken", outs, O_BR);
      tick();
      idle_in();
      for (int k = 0; k < 4; k++) begin
         #1 chk($sformatf("br_no_trap_%0d", k), outs, O_DEF);
         tick();
      end

      // Syscall, no branch: trap three cycles later
      syscall_id = 1;
      #1 chk("sc_issue", outs, O_DEF);
      tick();
      syscall_id = 0;
      #1 chk("sc_drain1", outs, O_STALL);
      tick();
      #1 chk("sc_drain2", outs, O_STALL);
      tick();
      #1 chk("sc_take", outs, O_TRAP);
      tick();
      #1 chk("sc_after", outs, O_DEF);
      tick();

      // Syscall with two frozen cycles mid-drain: trap shifts by two
      syscall_id = 1;
      #1 tick();
      syscall_id = 0;
      #1 chk("scf_drain1", outs, O_STALL);
      tick();
      mem_ready = 0;
      #1 chk("scf_frz0", outs, O_FRZ);
      tick();
      #1 chk("scf_frz1", outs, O_FRZ);
      tick();
      mem_ready = 1;
      #1 chk("scf_drain2", outs, O_STALL);
      tick();
      #1 chk("scf_take", outs, O_TRAP);
      tick();

      // Reset mid-sequence aborts without a trap
      syscall_id = 1;
      #1 tick();
      syscall_id = 0;
      #1 chk("rst_drain", outs, O_STALL);
      #2 reset = 1'b1;
      #1 chk("rst_during", outs, O_DEF);
      tick();
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1 chk($sformatf("rst_no_trap_%0d", k), outs, O_DEF);
         tick();
      end

      // Load-after-store with jump and flush layered on
      id_memread = 1; idex_memwrite = 1; jump_id = 1; flush_pipeline = 1;
      #1 chk("ld_st_jump_flush", outs, O_LSJF);
      tick();
      id_memread = 0; idex_memwrite = 0; flush_pipeline = 0;
      #1 chk("jump_only", outs, O_JMP);
      tick();
      idle_in();

`ifdef HAZARD_MEM_TIMEOUT_EN
      // Watchdog: 8 stalled cycles set mem_timeout and force one trap
      for (int k = 0; k < 8; k++) begin
         mem_ready = 0;
         #1 chk($sformatf("wd_pre_%0d", k), {9'd0, mem_timeout}, 10'd0);
         tick();
      end
      chk("wd_set", {9'd0, mem_timeout}, 10'd1);
      mem_ready = 1;
      #1 chk("wd_trap", outs, O_TRAP);
      tick();
      #1 chk("wd_no_repeat", outs, O_DEF);
      chk("wd_sticky", {9'd0, mem_timeout}, 10'd1);
      reset = 1'b1;
      #1 chk("wd_reset_clear", {9'd0, mem_timeout}, 10'd0);
      tick();
      reset = 1'b0;
      tick();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
